muldiv_unit: RTL

Iterative multi-cycle multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the execute-stage ALU. It consumes the ALU's MULT/MULTU/DIV/DIVU requests (funct 011000/011001/011010/011011) and rs/rt operands. It produces the 64-bit result as HI/LO, replacing the single-cycle product/quotient path. MTHI/MTLO writes also land here, and the pipeline stalls on `busy`.

---
 rtl/muldiv_unit.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Build option: define MULDIV_DIV_EN to include the restoring divider; otherwise DIV/DIVU report err.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             div_zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned AccW = 2 * WIDTH;
    localparam int unsigned CntW = 6;

    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;

    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [AccW-1:0]   acc_q;
    logic [AccW-1:0]   acc_d;
    logic [WIDTH-1:0]  opd_q;
    logic              is_div_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              ovf_q;
    logic              pend_err_q;
    logic              pend_dz_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              div_zero_q;
    logic              overflow_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;

    // Request decode and operand magnitudes for the accept edge
    logic              is_mul;
    logic              is_div;
    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;

    always_comb begin
        is_mul    = (funct == FnMult) || (funct == FnMultu);
        is_div    = DivEn && ((funct == FnDiv) || (funct == FnDivu));
        is_signed = (funct == FnMult) || (funct == FnDiv);
        a_neg     = is_signed && op_a[WIDTH-1];
        b_neg     = is_signed && op_b[WIDTH-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
    end

    // One radix-2 step: shift-add multiply or restoring divide, sharing acc_q
    logic [WIDTH:0] sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
`endif

    always_comb begin
        acc_d = acc_q;
        sum   = '0;
`ifdef MULDIV_DIV_EN
        rem_sh = '0;
        diff   = '0;
`endif
        if (is_div_q) begin
`ifdef MULDIV_DIV_EN
            rem_sh = {acc_q[AccW-1:WIDTH], acc_q[WIDTH-1]};
            diff   = rem_sh - {1'b0, opd_q};
            if (diff[WIDTH]) begin
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
`endif
        end else begin
            sum   = {1'b0, acc_q[AccW-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied at the FIX edge
    logic [AccW-1:0]  prod_v;
    logic [WIDTH-1:0] quo_v;
    logic [WIDTH-1:0] rem_v;

    always_comb begin
        prod_v = neg_res_q ? -acc_q : acc_q;
        quo_v  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_v  = neg_rem_q ? -acc_q[AccW-1:WIDTH] : acc_q[AccW-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opd_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_q      <= 1'b0;
            pend_err_q <= 1'b0;
            pend_dz_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            pend_err_q <= 1'b0;
            pend_dz_q  <= 1'b0;

            // Rejected requests complete one edge after acceptance
            if (pend_err_q || pend_dz_q) begin
                done_q     <= 1'b1;
                err_q      <= pend_err_q;
                div_zero_q <= pend_dz_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!is_mul && !is_div) begin
                            pend_err_q <= 1'b1;
                        end else if (is_div && (op_b == '0)) begin
                            pend_dz_q <= 1'b1;
                        end else begin
                            state_q   <= S_CALC;
                            busy_q    <= 1'b1;
                            cnt_q     <= '0;
                            is_div_q  <= is_div;
                            opd_q     <= is_div ? b_mag : a_mag;
                            acc_q     <= {WIDTH'(0), (is_div ? a_mag : b_mag)};
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            ovf_q     <= is_div && is_signed && (op_a == MinNeg) && (op_b == '1);
                        end
                    end else if (mt_we) begin
                        if (mt_sel) begin
                            hi_q <= mt_data;
                        end else begin
                            lo_q <= mt_data;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_v;
                        lo_q <= quo_v;
                    end else begin
                        hi_q <= prod_v[AccW-1:WIDTH];
                        lo_q <= prod_v[WIDTH-1:0];
                    end
                    done_q     <= 1'b1;
                    overflow_q <= ovf_q;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign div_zero = div_zero_q;
    assign overflow = overflow_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
